// File: rtl/stack_exec_ctrl.sv
// Stack-machine sequencer: owns the operand stack RAM and a WIDTH-bit ALU.
// Each accepted instruction is split into single-access steps
// (pop B, pop A, write, write). Every instruction ends in one DONE cycle
// that reports success or the reason it was rejected.
module stack_exec_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [WIDTH-1:0]      pc_in,
  output logic [WIDTH-1:0]      pc_out,
  output logic                  pc_load,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [DEPTH_LOG2:0]   depth,
  output logic [WIDTH-1:0]      tos
);

  localparam int                    CAP   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2+1:0] CAP_W = (DEPTH_LOG2+2)'(CAP);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_POP_B, S_POP_A, S_WR1, S_WR2, S_DONE
  } state_t;

  state_t                  r_state, w_next;
  logic [15:0]             r_instr;
  logic [WIDTH-1:0]        r_pc;
  logic [WIDTH-1:0]        r_a, r_b;
  logic [WIDTH-1:0]        r_mem [CAP];
  logic [DEPTH_LOG2:0]     r_depth;
  logic                    r_err;
  logic [1:0]              r_code;
  logic [WIDTH-1:0]        r_pc_out;

  logic [2:0]              w_grp, w_op;
  logic [WIDTH-1:0]        w_imm;
  logic                    w_unary, w_dup, w_swap, w_illegal;
  logic [1:0]              w_pops, w_push, w_need;
  logic [DEPTH_LOG2+1:0]   w_after;
  logic                    w_err;
  logic [1:0]              w_code;
  logic [WIDTH-1:0]        w_tos, w_wr_data;
  logic                    w_hs;

  // ALU: every result wraps modulo 2**WIDTH
  function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = '0 - a;
      3'b011:  r = a * b;
      3'b100:  r = a & b;
      3'b101:  r = a | b;
      3'b110:  r = a ^ b;
      default: r = ~a;
    endcase
    return r;
  endfunction

  // Compare: flag lands in bit 0 of the pushed word
  function automatic logic [WIDTH-1:0] cmp(input logic [2:0] op,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic f;
    case (op)
      3'b000:  f = (a == b);
      3'b001:  f = (a > b);
      3'b010:  f = (a != b);
      default: f = 1'b0;
    endcase
    return {{(WIDTH-1){1'b0}}, f};
  endfunction

  assign w_grp = r_instr[15:13];
  assign w_op  = r_instr[12:10];
  assign w_imm = {{(WIDTH-10){1'b0}}, r_instr[9:0]};
  assign w_hs  = instr_valid && (r_state == S_IDLE);
  assign w_tos = (r_depth != '0) ? r_mem[r_depth[DEPTH_LOG2-1:0] - 1'b1] : '0;

  // Decode the latched instruction into stack traffic and legality
  always_comb begin
    w_pops    = 2'd0;
    w_push    = 2'd0;
    w_illegal = 1'b0;
    w_unary   = (w_op == 3'b010) || (w_op == 3'b111);
    w_dup     = (w_grp == 3'b101) && (w_op == 3'b000);
    w_swap    = (w_grp == 3'b101) && (w_op == 3'b001);
    case (w_grp)
      3'b000: begin w_pops = w_unary ? 2'd1 : 2'd2; w_push = 2'd1; end
      3'b001: begin w_pops = 2'd1; w_push = 2'd1; end
      3'b010: w_push = 2'd1;
      3'b011: w_pops = 2'd1;
      3'b100: begin
        if (w_op > 3'b010) w_illegal = 1'b1;
        else begin w_pops = 2'd2; w_push = 2'd1; end
      end
      3'b101: begin
        if (w_dup)       w_push = 2'd1;
        else if (w_swap) begin w_pops = 2'd2; w_push = 2'd2; end
        else             w_illegal = 1'b1;
      end
      3'b110: w_push = 2'd1;
      default: w_pops = 2'd1;
    endcase
    // DUP pops nothing but still needs a word to copy
    w_need  = w_dup ? 2'd1 : w_pops;
    w_after = (DEPTH_LOG2+2)'(r_depth) - (DEPTH_LOG2+2)'(w_pops)
              + (DEPTH_LOG2+2)'(w_push);
    w_err   = 1'b1;
    if (w_illegal)                                 w_code = 2'b11;
    else if ((DEPTH_LOG2+1)'(w_need) > r_depth)    w_code = 2'b01;
    else if (w_after > CAP_W)                      w_code = 2'b10;
    else begin w_code = 2'b00; w_err = 1'b0; end
  end

  // Value written by the current WR state
  always_comb begin
    w_wr_data = '0;
    if (r_state == S_WR2) w_wr_data = r_a;
    else begin
      case (w_grp)
        3'b000:  w_wr_data = alu(w_op, r_a, w_unary ? '0 : r_b);
        3'b001:  w_wr_data = alu(w_op, r_a, w_imm);
        3'b010:  w_wr_data = w_imm;
        3'b100:  w_wr_data = cmp(w_op, r_a, r_b);
        3'b101:  w_wr_data = w_dup ? r_a : r_b;
        3'b110:  w_wr_data = r_pc;
        default: w_wr_data = '0;
      endcase
    end
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: one stack access per state, unneeded states skipped
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_hs) w_next = S_DECODE;
      S_DECODE: begin
        if (w_err)              w_next = S_DONE;
        else if (w_pops == 2'd2) w_next = S_POP_B;
        else if (w_pops == 2'd1) w_next = S_POP_A;
        else                    w_next = S_WR1;
      end
      S_POP_B:  w_next = S_POP_A;
      S_POP_A:  w_next = (w_push != 2'd0) ? S_WR1 : S_DONE;
      S_WR1:    w_next = w_swap ? S_WR2 : S_DONE;
      S_WR2:    w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and the latched error status
  always_comb begin
    instr_ready = (r_state == S_IDLE);
    done        = (r_state == S_DONE);
    err         = done && r_err;
    err_code    = done ? r_code : 2'b00;
    pc_load     = done && !r_err && (w_grp == 3'b111);
  end

  // Control state: depth, error status and the pc_out holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_depth  <= '0;
      r_err    <= 1'b0;
      r_code   <= 2'b00;
      r_pc_out <= '0;
    end else begin
      case (r_state)
        S_DECODE: begin r_err <= w_err; r_code <= w_code; end
        S_POP_B:  r_depth <= r_depth - 1'b1;
        S_POP_A: begin
          r_depth <= r_depth - 1'b1;
          if (w_grp == 3'b111) r_pc_out <= w_tos;
        end
        S_WR1, S_WR2: r_depth <= r_depth + 1'b1;
        default: ;
      endcase
    end
  end

  // Datapath: operand latches and stack RAM, no reset needed
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE:   if (w_hs) begin r_instr <= instr; r_pc <= pc_in; end
      S_DECODE: r_a <= w_tos;
      S_POP_B:  r_b <= w_tos;
      S_POP_A:  r_a <= w_tos;
      S_WR1, S_WR2: r_mem[r_depth[DEPTH_LOG2-1:0]] <= w_wr_data;
      default: ;
    endcase
  end

  assign depth  = r_depth;
  assign tos    = w_tos;
  assign pc_out = r_pc_out;

endmodule

// File: tb/tb_stack_exec_ctrl.sv
// Directed bench for stack_exec_ctrl: hand-computed results, latencies,
// error codes, full/empty boundaries, pc push/pop and mid-instruction reset.
module tb_stack_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic        pc_load;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  depth;
  logic [31:0] tos;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat;
  logic        e;
  logic [1:0]  code;
  logic        pcl;
  int          n_done;

  stack_exec_ctrl #(.WIDTH(32), .DEPTH_LOG2(7)) dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_in(pc_in), .pc_out(pc_out),
    .pc_load(pc_load), .done(done), .err(err), .err_code(err_code),
    .depth(depth), .tos(tos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] mk(input logic [2:0] g, input logic [2:0] o,
                                     input logic [9:0] imm);
    return {g, o, imm};
  endfunction

  // Offer one instruction (caller sits #1 after a rising edge, DUT idle),
  // then wait a bounded number of cycles for done.
  task automatic exec(input logic [15:0] ins, input logic [31:0] pc,
                      output int l, output logic er, output logic [1:0] cd,
                      output logic pl);
    instr = ins; pc_in = pc; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
    pc_in = $urandom;
    l = 1;
    while (done !== 1'b1 && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    er = err; cd = err_code; pl = pc_load;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; instr = '0; instr_valid = 1'b0; pc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", {err, err_code}, 0);
    check("rst_pcload", pc_load, 0);
    check("rst_pcout", pc_out, 0);
    check("rst_depth", depth, 0);
    check("rst_tos", tos, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: 5 - 7
    exec(mk(3'b010, 3'b000, 10'd5), 0, lat, e, code, pcl);
    check("push_lat", lat, 3);
    exec(mk(3'b010, 3'b000, 10'd7), 0, lat, e, code, pcl);
    check("push2_tos", tos, 32'd7);
    exec(mk(3'b000, 3'b001, 10'd0), 0, lat, e, code, pcl);
    check("sub_lat", lat, 5);
    check("sub_err", {e, code}, 0);
    check("sub_depth", depth, 1);
    check("sub_tos", tos, 32'hFFFF_FFFE);
    exec(mk(3'b011, 3'b000, 10'd0), 0, lat, e, code, pcl);
    check("pop_lat", lat, 3);
    check("pop_depth", depth, 0);

    // 2: 0x3FF * 0x3FF, then bitwise not
    exec(mk(3'b010, 3'b000, 10'h3FF), 0, lat, e, code, pcl);
    exec(mk(3'b001, 3'b011, 10'h3FF), 0, lat, e, code, pcl);
    check("muli_lat", lat, 4);
    check("muli_tos", tos, 32'h000F_F801);
    check("muli_depth", depth, 1);
    exec(mk(3'b000, 3'b111, 10'h155), 0, lat, e, code, pcl);
    check("not_lat", lat, 4);
    check("not_tos", tos, 32'hFFF0_07FE);
    check("not_depth", depth, 1);
    exec(mk(3'b000, 3'b010, 10'd0), 0, lat, e, code, pcl);
    check("neg_tos", tos, 32'h000F_F802);
    exec(mk(3'b011, 3'b000, 10'd0), 0, lat, e, code, pcl);

    // 3: errors on empty stack
    exec(mk(3'b011, 3'b000, 10'd0), 0, lat, e, code, pcl);
    check("udf_lat", lat, 2);
    check("udf_err", {e, code}, 3'b101);
    check("udf_depth", depth, 0);
    exec(mk(3'b100, 3'b011, 10'd0), 0, lat, e, code, pcl);
    check("ill_err", {e, code}, 3'b111);
    exec(mk(3'b101, 3'b000, 10'd0), 0, lat, e, code, pcl);
    check("dup_empty", {e, code}, 3'b101);
    check("after_err_ready", instr_ready, 1);
    check("after_err_done", done, 0);

    // 4: full stack boundaries
    for (int i = 0; i < 128; i++)
      exec(mk(3'b010, 3'b000, 10'(i)), 0, lat, e, code, pcl);
    check("full_depth", depth, 128);
    check("full_tos", tos, 32'd127);
    exec(mk(3'b010, 3'b000, 10'd1), 0, lat, e, code, pcl);
    check("ovf_err", {e, code}, 3'b110);
    check("ovf_depth", depth, 128);
    check("ovf_tos", tos, 32'd127);
    exec(mk(3'b000, 3'b000, 10'd0), 0, lat, e, code, pcl);
    check("full_add_err", {e, code}, 0);
    check("full_add_depth", depth, 127);
    check("full_add_tos", tos, 32'd253);

    reset_n = 1'b0;
    #1;
    check("rst2_depth", depth, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 5: swap, compare, dup
    exec(mk(3'b010, 3'b000, 10'd3), 0, lat, e, code, pcl);
    exec(mk(3'b010, 3'b000, 10'd9), 0, lat, e, code, pcl);
    exec(mk(3'b101, 3'b001, 10'd0), 0, lat, e, code, pcl);
    check("swap_lat", lat, 6);
    check("swap_tos", tos, 32'd3);
    check("swap_depth", depth, 2);
    exec(mk(3'b100, 3'b001, 10'd0), 0, lat, e, code, pcl);
    check("cmpgt_lat", lat, 5);
    check("cmpgt_tos", tos, 32'd1);
    check("cmpgt_depth", depth, 1);
    exec(mk(3'b101, 3'b000, 10'd0), 0, lat, e, code, pcl);
    check("dup_lat", lat, 3);
    check("dup_depth", depth, 2);
    check("dup_tos", tos, 32'd1);
    exec(mk(3'b100, 3'b010, 10'd0), 0, lat, e, code, pcl);
    check("cmpne_tos", tos, 32'd0);
    check("cmpne_depth", depth, 1);

    // 6: push_pc / pop_pc
    exec(mk(3'b110, 3'b000, 10'd0), 32'h0000_1234, lat, e, code, pcl);
    check("pushpc_lat", lat, 3);
    check("pushpc_tos", tos, 32'h0000_1234);
    check("pushpc_depth", depth, 2);
    exec(mk(3'b111, 3'b000, 10'd0), 0, lat, e, code, pcl);
    check("poppc_lat", lat, 3);
    check("poppc_load", pcl, 1);
    check("poppc_load_off", pc_load, 0);
    check("poppc_out", pc_out, 32'h0000_1234);
    check("poppc_depth", depth, 1);
    exec(mk(3'b011, 3'b000, 10'd0), 0, lat, e, code, pcl);
    check("pop_no_load", pcl, 0);
    check("pcout_held", pc_out, 32'h0000_1234);

    // Reset while a SWAP is popping
    exec(mk(3'b010, 3'b000, 10'd3), 0, lat, e, code, pcl);
    exec(mk(3'b010, 3'b000, 10'd9), 0, lat, e, code, pcl);
    instr = mk(3'b101, 3'b001, 10'd0); instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("busy_ready", instr_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midswap_depth", depth, 1);
    reset_n = 1'b0;
    #1;
    check("abort_depth", depth, 0);
    check("abort_ready", instr_ready, 1);
    n_done = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) n_done++;
      @(posedge clk); #1;
    end
    check("abort_no_done", n_done, 0);
    check("abort_depth2", depth, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
